// File: rtl/ultrasonic_scheduler.sv
// Ultrasonic ranging scheduler for an HC-SR04-style sensor.
// Fires a trigger pulse on a fixed period, times the returned echo in clk
// cycles, and aborts with an all-ones result when the echo never arrives or
// never ends. Results are published with a one-cycle valid strobe.
module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             echo_i,
    output logic             trig_o,
    output logic [CNT_W-1:0] echo_counter,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    // One phase counter serves both the trigger pulse and the two timeouts.
    localparam int PHASE_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int PH_W      = $clog2(PHASE_MAX + 1);
    localparam int PER_W     = $clog2(PERIOD_CYCLES + 1);

    localparam logic [PH_W-1:0]  TRIG_LAST   = PH_W'(TRIG_CYCLES - 1);
    localparam logic [PH_W-1:0]  TMO_LAST    = PH_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0] PERIOD_MAX  = PER_W'(PERIOD_CYCLES);
    localparam logic [PER_W-1:0] PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE,
        HOLDOFF
    } state_t;

    state_t           state;
    logic             echo_m;
    logic             echo_s;
    logic [PH_W-1:0]  phase_cnt;
    logic [PER_W-1:0] period_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic             period_done;

    // The period is complete on the edge where the counter reaches
    // PERIOD_CYCLES, so consecutive trigger rises are exactly PERIOD_CYCLES apart.
    assign period_done = (period_cnt >= PERIOD_LAST);

    // Two-flop synchronizer for the asynchronous echo pin.
    // NOTE: the second flop (echo_s) is the only echo copy the FSM may look at;
    // echo_m can still be metastable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo_i;
            echo_s <= echo_m;
        end
    end

    // Measurement FSM with registered outputs and all timing counters.
    // NOTE: sequential state uses non-blocking assignments only, so the order
    // of statements below never changes what the other branches observe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            trig_o       <= 1'b0;
            echo_counter <= '0;
            valid_o      <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
            phase_cnt    <= '0;
            period_cnt   <= '0;
            width_cnt    <= '0;
        end else begin
            // Strobes default low; only the transition into DONE raises them.
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;

            if (busy_o && period_cnt != PERIOD_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable_i && !echo_s) begin
                        state      <= TRIG;
                        trig_o     <= 1'b1;
                        busy_o     <= 1'b1;
                        period_cnt <= '0;
                        phase_cnt  <= '0;
                    end
                end

                TRIG: begin
                    if (phase_cnt == TRIG_LAST) begin
                        state     <= WAIT_RISE;
                        trig_o    <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                WAIT_RISE: begin
                    if (echo_s) begin
                        state     <= MEASURE;
                        width_cnt <= CNT_ONE;
                        phase_cnt <= '0;
                    end else if (phase_cnt == TMO_LAST) begin
                        state        <= DONE;
                        echo_counter <= CNT_MAX;
                        valid_o      <= 1'b1;
                        timeout_o    <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                MEASURE: begin
                    // Echo fall is checked first so it wins over a coincident timeout.
                    if (!echo_s) begin
                        state        <= DONE;
                        echo_counter <= width_cnt;
                        valid_o      <= 1'b1;
                    end else if (phase_cnt == TMO_LAST) begin
                        state        <= DONE;
                        echo_counter <= CNT_MAX;
                        valid_o      <= 1'b1;
                        timeout_o    <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                        if (width_cnt != CNT_MAX) begin
                            width_cnt <= width_cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state     <= HOLDOFF;
                    phase_cnt <= '0;
                end

                HOLDOFF: begin
                    // A stuck-high echo parks the FSM here; never retrigger mid-echo.
                    if (period_done && !echo_s) begin
                        if (enable_i) begin
                            state      <= TRIG;
                            trig_o     <= 1'b1;
                            period_cnt <= '0;
                            phase_cnt  <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    trig_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
- Sequences the HC-SR04-style ultrasonic sensor: periodically fires the trigger pulse, waits for and times the echo, and guards against a missing or stuck echo.
- Publishes each result as a 16-bit cycle count with a one-cycle valid strobe.
- Sits between the sensor pins and the tamagotchi game logic.
- Replaces free-running echo measurement with a scheduled, timeout-protected measurement loop.

Parameters:
- TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz).
- PERIOD_CYCLES, 3000000, minimum cycles between consecutive trigger rising edges (60 ms).
- TIMEOUT_CYCLES, 1500000, maximum cycles spent in WAIT_RISE, and separately in MEASURE, before abort.
- CNT_W, 16, width of echo count output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- enable_i  input  1  high = run measurement loop; low = stop after the current cycle.
- echo_i  input  1  raw sensor echo, asynchronous to clk.
- trig_o  output  1  sensor trigger pulse.
- echo_counter  output  CNT_W  last measured echo width in clk cycles; held between results.
- valid_o  output  1  one-cycle strobe when echo_counter updates.
- timeout_o  output  1  one-cycle strobe, coincident with valid_o, when the result is a timeout.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - trig_o = 0, echo_counter = 0, valid_o = 0, timeout_o = 0, busy_o = 0.
  - All counters = 0; sync flops = 0.
- echo_i passes through a 2-flop synchronizer; echo_s is the second flop. All echo decisions use echo_s, so a pin edge is visible 2 cycles later.
- Period counter:
  - Cleared on the cycle trig_o rises; increments every cycle while busy.
  - Saturates at PERIOD_CYCLES.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLDOFF.
- IDLE:
  - Go to TRIG when enable_i = 1 and echo_s = 0.
  - trig_o registered high on the first TRIG cycle, i.e. one cycle after enable_i is sampled high.
- TRIG:
  - trig_o = 1 for exactly TRIG_CYCLES cycles, then trig_o = 0 and go to WAIT_RISE.
  - Phase counter cleared on exit.
- WAIT_RISE:
  - echo_s = 1: go to MEASURE; width counter loaded with 1.
  - Phase counter reaches TIMEOUT_CYCLES-1: go to DONE with the timeout flag set.
- MEASURE:
  - Width counter increments each cycle echo_s = 1, saturating at 2^CNT_W-1 (no wrap).
  - echo_s = 0: go to DONE, result = width counter.
  - Phase counter reaches TIMEOUT_CYCLES-1 with echo still high: go to DONE with the timeout flag set.
- DONE (one cycle):
  - echo_counter <= result, or all-ones on timeout.
  - valid_o = 1; timeout_o = timeout flag.
  - Go to HOLDOFF.
- HOLDOFF:
  - Wait until the period counter = PERIOD_CYCLES and echo_s = 0.
  - Then go to TRIG if enable_i = 1, else IDLE.
  - A stuck-high echo keeps the FSM in HOLDOFF; the sensor is never retriggered mid-echo.
- enable_i low mid-measurement: current measurement completes and reports normally; the return to IDLE happens at the end of HOLDOFF.
- Measured width = number of cycles echo_s is high. A pin pulse of N cycles reports N (±1 for async sampling).
- Simultaneous echo fall and timeout in MEASURE: echo fall wins; a normal result is reported.
- valid_o and timeout_o are never high outside DONE.

Test Plan (bench parameters TRIG_CYCLES=5, PERIOD_CYCLES=200, TIMEOUT_CYCLES=100, 20 ns clk):
- Reset then enable_i=1, echo_i=0 -> trig_o high exactly 5 cycles, starting 1 cycle after enable_i is sampled; busy_o=1.
- Echo pulse of 40 cycles starting 10 cycles after trig_o falls -> one valid_o pulse, echo_counter=40, timeout_o=0.
- Next trigger rising edge -> exactly 200 cycles after the previous trig_o rising edge.
- No echo at all -> valid_o and timeout_o pulse together 100 cycles after WAIT_RISE entry; echo_counter=16'hFFFF.
- Echo held high 150 cycles -> timeout reported at 100 cycles of MEASURE; no new trig_o until echo_s has fallen and the period has elapsed.
- enable_i dropped during MEASURE -> result still reported, then FSM returns to IDLE with busy_o=0 and no further trig_o.
- rst pulled low mid-TRIG -> trig_o drops immediately (asynchronously); all outputs return to reset values.
